pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 112 +++++++++++
 tb/tb_pc_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Program-counter fetch stage: issues one instruction-memory request at a time,
// holds the returned word until decode accepts it, then steps or redirects the PC.
module pc_fetch #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   PCsrc,
  input  logic [ADDR_WIDTH-1:0]  ImmOp,
  output logic                   misaligned
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, ERR} state_e;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } fetch_rsp_t;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  req_q;
  logic                  vld_q;
  logic                  mis_q;
  fetch_rsp_t            rsp_q;

  logic                  hs;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic                  tgt_bad;

  // Next PC is always relative to the held instruction's address, wrapping mod 2^ADDR_WIDTH.
  assign hs      = vld_q & instr_ready;
  assign pc_d    = rsp_q.pc + (PCsrc ? ImmOp : ADDR_WIDTH'(4));
  assign tgt_bad = PCsrc & (pc_d[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      mis_q   <= 1'b0;
      rsp_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          addr_q  <= pc_q;
        end
        FETCH: begin
          state_q <= WAIT;
          req_q   <= 1'b0;
        end
        // Responses arriving in any other state are stale and dropped.
        WAIT: begin
          if (imem_rvalid) begin
            rsp_q.instr <= imem_rdata;
            rsp_q.pc    <= pc_q;
            vld_q       <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (hs) begin
            vld_q <= 1'b0;
            if (tgt_bad) begin
              mis_q   <= 1'b1;
              state_q <= ERR;
            end else begin
              pc_q    <= pc_d;
              addr_q  <= pc_d;
              req_q   <= 1'b1;
              state_q <= FETCH;
            end
          end
        end
        ERR: begin
          req_q <= 1'b0;
          vld_q <= 1'b0;
          mis_q <= 1'b1;
        end
        default: begin
          state_q <= ERR;
          req_q   <= 1'b0;
          vld_q   <= 1'b0;
          mis_q   <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = rsp_q.instr;
  assign instr_pc    = rsp_q.pc;
  assign instr_valid = vld_q;
  assign misaligned  = mis_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential fetch, stalls, redirects, misalignment,
// stray responses, reset mid-request, and PC wrap on a second instance.
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic        misaligned;

  logic        rst_n_w;
  logic        imem_req_w;
  logic [31:0] imem_addr_w;
  logic        imem_rvalid_w;
  logic [31:0] imem_rdata_w;
  logic [31:0] instr_w;
  logic [31:0] instr_pc_w;
  logic        instr_valid_w;
  logic        misaligned_w;
  logic        req_seen_w;
  logic [31:0] q_w[$];

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int pend;
  logic [31:0] pend_a;

  localparam logic [31:0] BAD = 32'hBADBAD00;

  pc_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .PCsrc(PCsrc), .ImmOp(ImmOp),
    .misaligned(misaligned)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n_w),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_rvalid(imem_rvalid_w), .imem_rdata(imem_rdata_w),
    .instr(instr_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w),
    .instr_ready(1'b1), .PCsrc(1'b0), .ImmOp(32'h0),
    .misaligned(misaligned_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_0000;
  endfunction

  // Latency-1 responder and request log for the wrap instance.
  initial begin
    imem_rvalid_w = 1'b0;
    imem_rdata_w  = '0;
    req_seen_w    = 1'b0;
    forever begin
      @(negedge clk);
      imem_rvalid_w = req_seen_w;
      if (req_seen_w) imem_rdata_w = mem(imem_addr_w);
      req_seen_w = imem_req_w;
      if (imem_req_w) q_w.push_back(imem_addr_w);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs for the next edge are set after this returns.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem(pend_a);
      end
    end
    if (imem_req) begin
      pend   = lat;
      pend_a = imem_addr;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rst_n_w = 1'b0;
    instr_ready = 1'b1; PCsrc = 1'b0; ImmOp = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    lat = 1; pend = 0; pend_a = '0;
    tick(); tick();

    chk("rst_req",   imem_req,    0);
    chk("rst_addr",  imem_addr,   0);
    chk("rst_instr", instr,       0);
    chk("rst_ipc",   instr_pc,    0);
    chk("rst_vld",   instr_valid, 0);
    chk("rst_mis",   misaligned,  0);
    chk("rst_addr_w", imem_addr_w, 32'hFFFF_FFFC);

    rst_n = 1'b1; rst_n_w = 1'b1;

    // Sequential fetch at latency 1: a request every third cycle.
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("seq_req%0d", k), imem_req, (k % 3 == 1));
      if (k % 3 == 1) chk($sformatf("seq_addr%0d", k), imem_addr, 4 * (k / 3));
      if (k % 3 == 2) chk($sformatf("seq_vld%0d", k), instr_valid, 0);
      if (k % 3 == 0) begin
        chk($sformatf("seq_vld%0d", k),   instr_valid, 1);
        chk($sformatf("seq_ipc%0d", k),   instr_pc,    4 * (k / 3 - 1));
        chk($sformatf("seq_instr%0d", k), instr,       mem(4 * (k / 3 - 1)));
      end
    end

    // Stall in HOLD; redirect inputs and a stray response must be ignored.
    instr_ready = 1'b0; PCsrc = 1'b1; ImmOp = 32'h6;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk($sformatf("stall_req%0d", s),   imem_req,    0);
      chk($sformatf("stall_vld%0d", s),   instr_valid, 1);
      chk($sformatf("stall_ipc%0d", s),   instr_pc,    32'h8);
      chk($sformatf("stall_instr%0d", s), instr,       mem(32'h8));
      if (s == 2) begin
        imem_rvalid = 1'b1;
        imem_rdata  = BAD;
      end
    end

    instr_ready = 1'b1; PCsrc = 1'b1; ImmOp = 32'hF8;
    tick();
    chk("jmp100_req",  imem_req,  1);
    chk("jmp100_addr", imem_addr, 32'h100);
    instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = '0;
    tick(); tick();
    chk("at100_vld", instr_valid, 1);
    chk("at100_ipc", instr_pc,    32'h100);

    // Backward branch, then a slower memory (latency 3).
    lat = 3;
    instr_ready = 1'b1; PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
    tick();
    chk("back_req",  imem_req,  1);
    chk("back_addr", imem_addr, 32'hF8);
    instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = '0;
    for (int w = 0; w < 3; w++) begin
      tick();
      chk($sformatf("lat3_vld%0d", w), instr_valid, 0);
      chk($sformatf("lat3_req%0d", w), imem_req,    0);
    end
    tick();
    chk("lat3_vld",   instr_valid, 1);
    chk("lat3_ipc",   instr_pc,    32'hF8);
    chk("lat3_instr", instr,       mem(32'hF8));
    lat = 1;

    instr_ready = 1'b1; PCsrc = 1'b1; ImmOp = 32'h8;
    tick();
    chk("fwd_addr", imem_addr, 32'h100);
    instr_ready = 1'b0; PCsrc = 1'b0;
    tick(); tick();
    chk("pre_err_ipc", instr_pc, 32'h100);

    // Misaligned redirect is terminal until reset.
    instr_ready = 1'b1; PCsrc = 1'b1; ImmOp = 32'h6;
    tick();
    chk("err_mis", misaligned,  1);
    chk("err_vld", instr_valid, 0);
    chk("err_req", imem_req,    0);
    PCsrc = 1'b0; ImmOp = '0;
    for (int e = 0; e < 6; e++) begin
      tick();
      chk($sformatf("errh_req%0d", e), imem_req,    0);
      chk($sformatf("errh_mis%0d", e), misaligned,  1);
      chk($sformatf("errh_vld%0d", e), instr_valid, 0);
      if (e == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = BAD;
      end
    end

    // Reset clears the error without waiting for a clock edge.
    rst_n = 1'b0; pend = 0;
    #1;
    chk("arst_mis", misaligned, 0);
    tick();
    rst_n = 1'b1; lat = 3;
    tick();
    chk("rf_req",  imem_req,  1);
    chk("rf_addr", imem_addr, 0);
    tick();
    // Abandon the request mid-WAIT.
    rst_n = 1'b0; pend = 0;
    #1;
    chk("mid_req",  imem_req,    0);
    chk("mid_vld",  instr_valid, 0);
    chk("mid_addr", imem_addr,   0);
    tick();
    rst_n = 1'b1; lat = 2;
    imem_rvalid = 1'b1; imem_rdata = BAD;
    tick();
    chk("late_req",  imem_req,    1);
    chk("late_addr", imem_addr,   0);
    chk("late_vld",  instr_valid, 0);
    imem_rvalid = 1'b1; imem_rdata = BAD;
    tick();
    chk("late_vld1", instr_valid, 0);
    tick();
    chk("late_vld2", instr_valid, 0);
    tick();
    chk("late_vld3",  instr_valid, 1);
    chk("late_instr", instr,       mem(32'h0));
    chk("late_ipc",   instr_pc,    0);

    // Wrap instance: RESET_PC near the top of the address space.
    chk("wrap_n", (q_w.size() >= 3), 1);
    if (q_w.size() >= 3) begin
      chk("wrap_a0", q_w[0], 32'hFFFF_FFFC);
      chk("wrap_a1", q_w[1], 32'h0);
      chk("wrap_a2", q_w[2], 32'h4);
    end
    chk("wrap_mis", misaligned_w, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
